wb_bus_controller: RTL and testbench
====================================

# wb_bus_controller

Single-master Wishbone bus controller between the `cpu` data port and the SoC slaves (`ram_wishbone`, `led_wishbone`, `vga_wishbone`). It latches each CPU data request and decodes the address to one slave strobe. It then waits for that slave's acknowledge, or times out, and returns one registered ACK or ERR pulse with read data to the CPU. It replaces the tie-off wiring (`STB_I` fixed high, direct `DAT_O` connection) in the board top level.

## Interface
Parameters:
- `LED_ADDR`, 32'hFFFF0000: exact address of the LED register.
- `VGA_BASE`, 16'hEEEE: upper 16 address bits selecting the VGA window (0xEEEE0000–0xEEEEFFFF).
- `TIMEOUT`, 8'd16: cycles in REQ without a selected ACK before ERR. Legal range 2–255.

Ports:
- `CLK_I` in 1: system clock; all logic on the rising edge.
- `RST_I` in 1: synchronous, active-high reset.
- `M_STB_I` in 1: CPU request strobe.
- `M_WE_I` in 1: CPU write enable.
- `M_ADR_I` in 32: CPU address.
- `M_DAT_I` in 32: CPU write data.
- `M_DAT_O` out 32: read data to CPU.
- `M_ACK_O` out 1: one-cycle completion pulse.
- `M_ERR_O` out 1: one-cycle timeout pulse.
- `RAM_STB_O`, `LED_STB_O`, `VGA_STB_O` out 1 each: slave strobes, at most one high.
- `S_WE_O` out 1, `S_ADR_O` out 32, `S_DAT_O` out 32: latched request, shared by all slaves.
- `RAM_ACK_I`, `LED_ACK_I`, `VGA_ACK_I` in 1 each: slave acknowledges.
- `RAM_DAT_I`, `VGA_DAT_I` in 32: slave read data. The LED slave is write-only.
- `ERR_CNT_O` out 8: saturating count of timeouts since reset.

## Operation
- The controller has three states: IDLE, REQ and DONE.
- **IDLE:** when `M_STB_I`=1:
  - latch `M_WE_I`, `M_ADR_I` and `M_DAT_I` into `S_*_O`;
  - decode and register the slave select, with priority as follows:
    - `M_ADR_I`==`LED_ADDR` selects LED;
    - otherwise `M_ADR_I[31:16]`==`VGA_BASE` selects VGA;
    - otherwise RAM;
  - clear the timeout counter and go to REQ.
- **REQ:**
  - Only the selected `*_STB_O` is high.
  - Each cycle, sample the selected `*_ACK_I`. ACKs from unselected slaves are ignored.
  - When the selected ACK is 1, load `M_DAT_O`:
    - read from RAM: `RAM_DAT_I`;
    - read from VGA: `VGA_DAT_I`;
    - read from LED, or any write: 32'h0.
  - Then set the done flag to ACK and go to DONE.
  - When there is no ACK and the counter equals `TIMEOUT`-1:
    - load `M_DAT_O`=0;
    - set the done flag to ERR;
    - increment `ERR_CNT_O`, saturating at 8'hFF;
    - go to DONE.
  - Otherwise increment the counter.
- **DONE:**
  - All `*_STB_O` are low.
  - `M_ACK_O` or `M_ERR_O` is high for exactly this cycle, never both.
  - Next state is always IDLE.
- **Master rule:** `M_STB_I` is sampled only in IDLE. Deasserting it during REQ or DONE does not abort the cycle; the transaction completes normally.
- `M_DAT_O` holds its value until the next completion.
- `S_WE_O`, `S_ADR_O` and `S_DAT_O` hold their latched values outside REQ.
- Boundary cases:
  - ACK arriving in the same cycle as the counter reaching `TIMEOUT`-1: the ACK wins and no ERR is raised.
  - An ACK in IDLE or DONE is ignored.

## Timing
- **Reset values** (on `RST_I`=1 at a clock edge, from any state, including mid-REQ):
  - state returns to IDLE;
  - all `*_STB_O` = 0, `M_ACK_O` = 0, `M_ERR_O` = 0;
  - `M_DAT_O` = 0, `S_WE_O` = 0, `S_ADR_O` = 0, `S_DAT_O` = 0;
  - counter = 0, `ERR_CNT_O` = 0.
  - A transaction in flight is dropped without an ACK pulse.
- **Latency:** request sampled at edge N; STB_O high from N+1. If the slave ACKs in the first REQ cycle, `M_ACK_O` is high in cycle N+2. Each slave wait cycle adds 1.
- **Timeout:** STB_O is high for exactly `TIMEOUT` cycles. `M_ERR_O` is high in the following cycle.
- **Back-to-back:** a request held high through DONE is accepted in the IDLE cycle after DONE. Minimum issue interval is 3 cycles.
- **Output registration:** all outputs are registered. There is no combinational path from any input to any output.

## Test plan
- **RAM read:** `M_ADR_I`=0x00000100, `M_WE_I`=0, with `RAM_ACK_I` high in the first REQ cycle and `RAM_DAT_I`=0xDEADBEEF.
  - Required: `RAM_STB_O` high for 1 cycle, then `M_ACK_O` high for 1 cycle with `M_DAT_O`=0xDEADBEEF, 2 cycles after the request.
- **LED write:** address 0xFFFF0000, `M_WE_I`=1, `M_DAT_I`=0x0000A5A5.
  - Required: `LED_STB_O` high, `S_DAT_O`=0x0000A5A5, `S_WE_O`=1; after `LED_ACK_I`, `M_ACK_O` pulses with `M_DAT_O`=0.
- **VGA read with wait states:** address 0xEEEE0040, `VGA_ACK_I` delayed 3 cycles.
  - Required: `VGA_STB_O` high for 4 cycles, `M_ACK_O` in cycle 5 after the request, data passed through.
  - `RAM_ACK_I` held high throughout must be ignored.
- **Timeout:** `TIMEOUT`=16, RAM address, no ACK ever.
  - Required: `RAM_STB_O` high for 16 cycles, then `M_ERR_O` pulse with `M_DAT_O`=0 and `ERR_CNT_O` 0→1.
  - Repeat 300 times: `ERR_CNT_O` saturates at 255.
- **ACK/timeout tie:** ACK asserted exactly in the 16th REQ cycle.
  - Required: `M_ACK_O`=1 and `M_ERR_O`=0, `ERR_CNT_O` unchanged.
- **Reset mid-transaction:** `RST_I` asserted in the 2nd REQ cycle.
  - Required: next cycle all strobes, ACK and ERR are 0, and `M_DAT_O`=0.
  - A new request after reset completes normally.

Source files
------------

// File: rtl/wb_bus_controller.sv
// wb_bus_controller
// -----------------------------------------------------------------------------
// Single-master Wishbone bus controller between the CPU data port and the SoC
// slaves (RAM, LED, VGA). Each CPU request is latched in IDLE, decoded to one
// slave strobe, held in REQ until that slave acknowledges or a timeout expires,
// and completed with a single-cycle ACK or ERR pulse in DONE.
//
// Ports
//   CLK_I, RST_I            : clock (rising edge), synchronous active-high reset
//   M_STB_I/M_WE_I          : CPU request strobe / write enable
//   M_ADR_I/M_DAT_I         : CPU address / write data
//   M_DAT_O/M_ACK_O/M_ERR_O : read data, completion pulse, timeout pulse
//   RAM/LED/VGA_STB_O       : one-hot slave strobes (at most one high)
//   S_WE_O/S_ADR_O/S_DAT_O  : latched request shared by all slaves
//   RAM/LED/VGA_ACK_I       : slave acknowledges
//   RAM_DAT_I/VGA_DAT_I     : slave read data (LED is write-only)
//   ERR_CNT_O               : saturating count of timeouts since reset
//
// All outputs come straight from flops; nothing combinational reaches a port.
// -----------------------------------------------------------------------------
module wb_bus_controller #(
  parameter logic [31:0] LED_ADDR = 32'hFFFF_0000,
  parameter logic [15:0] VGA_BASE = 16'hEEEE,
  parameter logic [7:0]  TIMEOUT  = 8'd16
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        M_STB_I,
  input  logic        M_WE_I,
  input  logic [31:0] M_ADR_I,
  input  logic [31:0] M_DAT_I,
  output logic [31:0] M_DAT_O,
  output logic        M_ACK_O,
  output logic        M_ERR_O,
  output logic        RAM_STB_O,
  output logic        LED_STB_O,
  output logic        VGA_STB_O,
  output logic        S_WE_O,
  output logic [31:0] S_ADR_O,
  output logic [31:0] S_DAT_O,
  input  logic        RAM_ACK_I,
  input  logic        LED_ACK_I,
  input  logic        VGA_ACK_I,
  input  logic [31:0] RAM_DAT_I,
  input  logic [31:0] VGA_DAT_I,
  output logic [7:0]  ERR_CNT_O
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_RAM = 2'd0,
    SEL_LED = 2'd1,
    SEL_VGA = 2'd2
  } sel_t;

  // Address decode: exact LED match beats the VGA window; everything else is RAM.
  function automatic sel_t decode_sel(input logic [31:0] adr);
    sel_t sel;
    if (adr == LED_ADDR) begin
      sel = SEL_LED;
    end else if (adr[31:16] == VGA_BASE) begin
      sel = SEL_VGA;
    end else begin
      sel = SEL_RAM;
    end
    return sel;
  endfunction

  // Registered state
  state_t      state_r,   state_s;
  sel_t        sel_r,     sel_s;
  logic [7:0]  cnt_r,     cnt_s;
  logic [7:0]  err_cnt_r, err_cnt_s;
  logic [31:0] m_dat_r,   m_dat_s;
  logic        ack_r,     ack_s;
  logic        err_r,     err_s;
  logic        s_we_r,    s_we_s;
  logic [31:0] s_adr_r,   s_adr_s;
  logic [31:0] s_dat_r,   s_dat_s;
  logic        ram_stb_r, ram_stb_s;
  logic        led_stb_r, led_stb_s;
  logic        vga_stb_r, vga_stb_s;

  // Acknowledge of the currently selected slave only
  logic        sel_ack_s;

  // Selected-slave acknowledge mux; unselected ACKs never reach the FSM.
  always_comb begin
    sel_ack_s = 1'b0;
    case (sel_r)
      SEL_RAM: sel_ack_s = RAM_ACK_I;
      SEL_LED: sel_ack_s = LED_ACK_I;
      SEL_VGA: sel_ack_s = VGA_ACK_I;
      default: sel_ack_s = 1'b0;
    endcase
  end

  // Next-state and next-output logic; strobes are computed for the next cycle
  // so that they can be registered and still line up with the REQ state.
  always_comb begin
    state_s   = state_r;
    sel_s     = sel_r;
    cnt_s     = cnt_r;
    err_cnt_s = err_cnt_r;
    m_dat_s   = m_dat_r;
    s_we_s    = s_we_r;
    s_adr_s   = s_adr_r;
    s_dat_s   = s_dat_r;
    ack_s     = 1'b0;
    err_s     = 1'b0;
    ram_stb_s = 1'b0;
    led_stb_s = 1'b0;
    vga_stb_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (M_STB_I) begin
          s_we_s    = M_WE_I;
          s_adr_s   = M_ADR_I;
          s_dat_s   = M_DAT_I;
          sel_s     = decode_sel(M_ADR_I);
          cnt_s     = 8'd0;
          state_s   = ST_REQ;
          ram_stb_s = (decode_sel(M_ADR_I) == SEL_RAM);
          led_stb_s = (decode_sel(M_ADR_I) == SEL_LED);
          vga_stb_s = (decode_sel(M_ADR_I) == SEL_VGA);
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_REQ: begin
        // ACK is tested before the timeout so a coincident ACK wins.
        if (sel_ack_s) begin
          if (s_we_r) begin
            m_dat_s = 32'h0000_0000;
          end else if (sel_r == SEL_RAM) begin
            m_dat_s = RAM_DAT_I;
          end else if (sel_r == SEL_VGA) begin
            m_dat_s = VGA_DAT_I;
          end else begin
            m_dat_s = 32'h0000_0000;
          end
          ack_s   = 1'b1;
          state_s = ST_DONE;
        end else if (cnt_r == (TIMEOUT - 8'd1)) begin
          m_dat_s = 32'h0000_0000;
          err_s   = 1'b1;
          if (err_cnt_r != 8'hFF) begin
            err_cnt_s = err_cnt_r + 8'd1;
          end else begin
            err_cnt_s = err_cnt_r;
          end
          state_s = ST_DONE;
        end else begin
          cnt_s     = cnt_r + 8'd1;
          state_s   = ST_REQ;
          ram_stb_s = (sel_r == SEL_RAM);
          led_stb_s = (sel_r == SEL_LED);
          vga_stb_s = (sel_r == SEL_VGA);
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_r   <= ST_IDLE;
      sel_r     <= SEL_RAM;
      cnt_r     <= 8'd0;
      err_cnt_r <= 8'd0;
      m_dat_r   <= 32'h0000_0000;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      s_we_r    <= 1'b0;
      s_adr_r   <= 32'h0000_0000;
      s_dat_r   <= 32'h0000_0000;
      ram_stb_r <= 1'b0;
      led_stb_r <= 1'b0;
      vga_stb_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      sel_r     <= sel_s;
      cnt_r     <= cnt_s;
      err_cnt_r <= err_cnt_s;
      m_dat_r   <= m_dat_s;
      ack_r     <= ack_s;
      err_r     <= err_s;
      s_we_r    <= s_we_s;
      s_adr_r   <= s_adr_s;
      s_dat_r   <= s_dat_s;
      ram_stb_r <= ram_stb_s;
      led_stb_r <= led_stb_s;
      vga_stb_r <= vga_stb_s;
    end
  end

  assign M_DAT_O   = m_dat_r;
  assign M_ACK_O   = ack_r;
  assign M_ERR_O   = err_r;
  assign RAM_STB_O = ram_stb_r;
  assign LED_STB_O = led_stb_r;
  assign VGA_STB_O = vga_stb_r;
  assign S_WE_O    = s_we_r;
  assign S_ADR_O   = s_adr_r;
  assign S_DAT_O   = s_dat_r;
  assign ERR_CNT_O = err_cnt_r;

endmodule

// File: tb/tb_wb_bus_controller.sv
// tb_wb_bus_controller
// Directed testbench for wb_bus_controller with hand-computed expectations.
// Inputs change 1 ns after a rising edge; outputs are checked at the same point.
module tb_wb_bus_controller;

  logic        clk;
  logic        rst;
  logic        m_stb;
  logic        m_we;
  logic [31:0] m_adr;
  logic [31:0] m_dat_in;
  logic [31:0] m_dat_out;
  logic        m_ack;
  logic        m_err;
  logic        ram_stb;
  logic        led_stb;
  logic        vga_stb;
  logic        s_we;
  logic [31:0] s_adr;
  logic [31:0] s_dat;
  logic        ram_ack;
  logic        led_ack;
  logic        vga_ack;
  logic [31:0] ram_dat;
  logic [31:0] vga_dat;
  logic [7:0]  err_cnt;

  int n_checks;
  int n_pass;

  wb_bus_controller dut (
    .CLK_I     (clk),
    .RST_I     (rst),
    .M_STB_I   (m_stb),
    .M_WE_I    (m_we),
    .M_ADR_I   (m_adr),
    .M_DAT_I   (m_dat_in),
    .M_DAT_O   (m_dat_out),
    .M_ACK_O   (m_ack),
    .M_ERR_O   (m_err),
    .RAM_STB_O (ram_stb),
    .LED_STB_O (led_stb),
    .VGA_STB_O (vga_stb),
    .S_WE_O    (s_we),
    .S_ADR_O   (s_adr),
    .S_DAT_O   (s_dat),
    .RAM_ACK_I (ram_ack),
    .LED_ACK_I (led_ack),
    .VGA_ACK_I (vga_ack),
    .RAM_DAT_I (ram_dat),
    .VGA_DAT_I (vga_dat),
    .ERR_CNT_O (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one IDLE sampling edge.
  task automatic issue(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    m_adr    = adr;
    m_we     = we;
    m_dat_in = dat;
    m_stb    = 1'b1;
    step();
    m_stb    = 1'b0;
  endtask

  // Wait (bounded) for the ACK/ERR pulse.
  task automatic wait_done();
    int n;
    n = 0;
    while (!(m_ack || m_err) && n < 64) begin
      step();
      n++;
    end
    if (!(m_ack || m_err)) begin
      check("wait_done_bound", 32'd0, 32'd1);
    end
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    m_stb    = 1'b0;
    m_we     = 1'b0;
    m_adr    = 32'h0;
    m_dat_in = 32'h0;
    ram_ack  = 1'b0;
    led_ack  = 1'b0;
    vga_ack  = 1'b0;
    ram_dat  = 32'h0;
    vga_dat  = 32'h0;
    step();
    step();

    // Reset state
    check("rst_strobes", {29'd0, ram_stb, led_stb, vga_stb}, 32'd0);
    check("rst_ack_err", {30'd0, m_ack, m_err}, 32'd0);
    check("rst_mdat", m_dat_out, 32'h0);
    check("rst_errcnt", {24'd0, err_cnt}, 32'd0);
    rst = 1'b0;
    step();

    // RAM read, ACK in first REQ cycle (ACK already high in IDLE is ignored)
    ram_ack = 1'b1;
    ram_dat = 32'hDEAD_BEEF;
    step();
    check("idle_ack_ignored", {31'd0, m_ack}, 32'd0);
    issue(32'h0000_0100, 1'b0, 32'h0);
    check("ram_stb", {29'd0, ram_stb, led_stb, vga_stb}, 32'b100);
    check("ram_adr", s_adr, 32'h0000_0100);
    check("ram_ack_early", {31'd0, m_ack}, 32'd0);
    step();
    check("ram_ack", {30'd0, m_ack, m_err}, 32'b10);
    check("ram_data", m_dat_out, 32'hDEAD_BEEF);
    check("ram_stb_done", {31'd0, ram_stb}, 32'd0);
    ram_ack = 1'b0;
    step();
    check("ram_ack_one_cycle", {31'd0, m_ack}, 32'd0);
    check("mdat_hold", m_dat_out, 32'hDEAD_BEEF);

    // LED write
    ram_dat = 32'h1111_2222;
    issue(32'hFFFF_0000, 1'b1, 32'h0000_A5A5);
    check("led_stb", {29'd0, ram_stb, led_stb, vga_stb}, 32'b010);
    check("led_sdat", s_dat, 32'h0000_A5A5);
    check("led_swe", {31'd0, s_we}, 32'd1);
    led_ack = 1'b1;
    step();
    check("led_ack", {30'd0, m_ack, m_err}, 32'b10);
    check("led_data_zero", m_dat_out, 32'h0);
    check("led_sdat_hold", s_dat, 32'h0000_A5A5);
    led_ack = 1'b0;
    step();

    // VGA read with 3 wait states, RAM ACK held high and ignored
    ram_ack = 1'b1;
    vga_dat = 32'h1234_5678;
    issue(32'hEEEE_0040, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("vga_stb_c%0d", i), {29'd0, ram_stb, led_stb, vga_stb}, 32'b001);
      check($sformatf("vga_noack_c%0d", i), {30'd0, m_ack, m_err}, 32'd0);
      if (i == 3) vga_ack = 1'b1;
      step();
    end
    check("vga_ack", {30'd0, m_ack, m_err}, 32'b10);
    check("vga_data", m_dat_out, 32'h1234_5678);
    vga_ack = 1'b0;
    ram_ack = 1'b0;
    step();

    // Timeout on RAM
    issue(32'h0000_0200, 1'b0, 32'h0);
    n = 0;
    while (ram_stb && n < 40) begin
      n++;
      step();
    end
    check("to_stb_cycles", n, 32'd16);
    check("to_err", {30'd0, m_ack, m_err}, 32'b01);
    check("to_data_zero", m_dat_out, 32'h0);
    check("to_errcnt", {24'd0, err_cnt}, 32'd1);
    step();
    check("to_err_one_cycle", {31'd0, m_err}, 32'd0);

    // ACK coinciding with the last timeout cycle
    ram_dat = 32'hCAFE_F00D;
    issue(32'h0000_0300, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) ram_ack = 1'b1;
      step();
    end
    check("tie_ack_wins", {30'd0, m_ack, m_err}, 32'b10);
    check("tie_data", m_dat_out, 32'hCAFE_F00D);
    check("tie_errcnt", {24'd0, err_cnt}, 32'd1);
    ram_ack = 1'b0;
    step();

    // Back-to-back: request held high through DONE, issue interval 3
    ram_ack = 1'b1;
    ram_dat = 32'h0000_00B2;
    m_adr   = 32'h0000_0400;
    m_we    = 1'b0;
    m_stb   = 1'b1;
    step();
    check("b2b_req1", {31'd0, ram_stb}, 32'd1);
    step();
    check("b2b_done1", {30'd0, m_ack, ram_stb}, 32'b10);
    step();
    check("b2b_idle", {30'd0, m_ack, ram_stb}, 32'b00);
    step();
    check("b2b_req2", {31'd0, ram_stb}, 32'd1);
    m_stb = 1'b0;
    step();
    check("b2b_done2", {31'd0, m_ack}, 32'd1);
    ram_ack = 1'b0;
    step();

    // Reset in the 2nd REQ cycle (slave ACKs in that cycle, reset wins)
    issue(32'h0000_0500, 1'b0, 32'h0);
    step();
    check("rst_mid_stb", {31'd0, ram_stb}, 32'd1);
    rst     = 1'b1;
    ram_ack = 1'b1;
    step();
    check("rst_mid_strobes", {29'd0, ram_stb, led_stb, vga_stb}, 32'd0);
    check("rst_mid_ack_err", {30'd0, m_ack, m_err}, 32'd0);
    check("rst_mid_mdat", m_dat_out, 32'h0);
    check("rst_mid_errcnt", {24'd0, err_cnt}, 32'd0);
    check("rst_mid_sadr", s_adr, 32'h0);
    rst     = 1'b0;
    ram_ack = 1'b0;
    step();

    // New request after reset
    vga_dat = 32'h0BAD_F00D;
    vga_ack = 1'b1;
    issue(32'hEEEE_FFFC, 1'b0, 32'h0);
    check("post_rst_stb", {29'd0, ram_stb, led_stb, vga_stb}, 32'b001);
    step();
    check("post_rst_ack", {30'd0, m_ack, m_err}, 32'b10);
    check("post_rst_data", m_dat_out, 32'h0BAD_F00D);
    vga_ack = 1'b0;
    step();

    // 300 timeouts: counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      issue(32'h0000_0600, 1'b0, 32'h0);
      wait_done();
      step();
      if (i == 0) check("sat_first", {24'd0, err_cnt}, 32'd1);
      if (i == 254) check("sat_255", {24'd0, err_cnt}, 32'd255);
    end
    check("sat_final", {24'd0, err_cnt}, 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
